// File: rtl/sh7604_sysctl_pkg.sv
// sh7604_sysctl_pkg -- shared types and constants for the SH7604 system controller.
// Optional feature macro: SH7604_MSTP_EN (module-stop bits of SBYCR become writable,
// readable and drive the mstp output). Without it those bits read 0 and mstp is tied 0.
package sh7604_sysctl_pkg;

    localparam logic [31:0] SBYCR_ADDR = 32'hFFFF_FE91;

    typedef struct packed {
        logic       sby;   // bit7: SLEEP enters software standby
        logic       hiz;   // bit6: pins high-Z in standby
        logic       rsv;   // bit5: reserved, always 0
        logic [4:0] mstp;  // bits4:0: module-stop
    } sbycr_t;

    localparam sbycr_t SBYCR_INIT = '0;

`ifdef SH7604_MSTP_EN
    localparam logic [7:0] SBYCR_WMASK = 8'hDF;
    localparam logic [7:0] SBYCR_RMASK = 8'hDF;
`else
    localparam logic [7:0] SBYCR_WMASK = 8'hC0;
    localparam logic [7:0] SBYCR_RMASK = 8'hC0;
`endif

    typedef enum logic [1:0] {
        ST_RESET,
        ST_RUN,
        ST_STANDBY,
        ST_WAKE
    } sysctl_state_t;

    typedef enum logic {
        RST_POWER_ON,
        RST_MANUAL
    } rst_type_t;

endpackage

// File: rtl/sh7604_sysctl_if.sv
// sh7604_sysctl_if -- internal peripheral bus port of the system controller.
interface sh7604_sysctl_if;
    logic [31:0] ibus_a;
    logic [31:0] ibus_di;
    logic [3:0]  ibus_ba;
    logic        ibus_we;
    logic        ibus_req;
    logic [31:0] ibus_do;
    logic        ibus_busy;
    logic        ibus_act;

    modport master (
        output ibus_a, ibus_di, ibus_ba, ibus_we, ibus_req,
        input  ibus_do, ibus_busy, ibus_act
    );

    modport slave (
        input  ibus_a, ibus_di, ibus_ba, ibus_we, ibus_req,
        output ibus_do, ibus_busy, ibus_act
    );
endinterface

// File: rtl/sh7604_sysctl_prescaler.sv
// sh7604_sysctl_prescaler -- 13-bit shared prescaler and divided clock-enable decode.
// Counts one per tick, can be cleared on a tick and is frozen (outputs forced 0) by halt.
module sh7604_sysctl_prescaler (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick,
    input  logic       clear,
    input  logic       halt,
    output logic [7:0] ce      // {8192,4096,1024,512,256,128,64,2}
);
    logic [12:0] psc;

    // Prescale counter: clear wins over count, halt freezes it.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples
        // pre-edge values regardless of process ordering.
        if (!rst_n) begin
            psc <= '0;
        end else if (tick) begin
            if (clear) begin
                psc <= '0;
            end else if (!halt) begin
                psc <= psc + 13'd1;
            end
        end
    end

    // Enable for divide-by-2^k fires when the low k counter bits are all ones.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        ce = '0;
        if (!halt) begin
            ce[0] = psc[0];
            ce[1] = &psc[5:0];
            ce[2] = &psc[6:0];
            ce[3] = &psc[7:0];
            ce[4] = &psc[8:0];
            ce[5] = &psc[9:0];
            ce[6] = &psc[11:0];
            ce[7] = &psc[12:0];
        end
    end
endmodule

// File: rtl/sh7604_sysctl.sv
// sh7604_sysctl -- SH7604 standby/reset sequencer, shared prescaler and SBYCR owner.
// Optional feature macro: SH7604_MSTP_EN (drives SBYCR module-stop bits onto mstp).
module sh7604_sysctl
    import sh7604_sysctl_pkg::*;
#(
    parameter int unsigned RST_HOLD = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            ce_r,
    input  logic            ce_f,
    input  logic            en,
    input  logic            res_n,
    input  logic            nmi_n,
    input  logic            sleep_req,
    input  logic            wdt_pres,
    input  logic            wdt_mres,
    input  logic            wdt_ovf,
    sh7604_sysctl_if.slave  bus,
    output logic            clk2_ce,
    output logic            clk64_ce,
    output logic            clk128_ce,
    output logic            clk256_ce,
    output logic            clk512_ce,
    output logic            clk1024_ce,
    output logic            clk4096_ce,
    output logic            clk8192_ce,
    output logic            sby,
    output logic            pres,
    output logic            mres,
    output logic            stby_exit,
    output logic            hiz,
    output logic [4:0]      mstp
);
    localparam int unsigned HOLD_W = $clog2(RST_HOLD + 1);
    localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(RST_HOLD);

    sysctl_state_t     state, state_nx;
    rst_type_t         rst_type, rst_type_nx;
    logic [HOLD_W-1:0] hold, hold_nx;
    logic              nmi_prev;
    sbycr_t            sbycr;
    logic [31:0]       rd_data;
    logic [7:0]        ce_vec;

    logic tick, por_cause, reg_sel, reg_wr, psc_clear, psc_halt;

    assign tick      = en && ce_r;
    assign por_cause = !res_n || wdt_pres;
    assign reg_sel   = (bus.ibus_a == SBYCR_ADDR);
    assign reg_wr    = reg_sel && bus.ibus_we && bus.ibus_req;

    // Sequencer state register; nmi_prev holds the previous tick's NMI sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_RESET;
            rst_type <= RST_POWER_ON;
            hold     <= HOLD_INIT;
            nmi_prev <= 1'b1;
        end else if (tick) begin
            state    <= state_nx;
            rst_type <= rst_type_nx;
            hold     <= hold_nx;
            nmi_prev <= nmi_n;
        end
    end

    // Next state: reset causes override everything, power-on beats manual.
    always_comb begin
        state_nx    = state;
        rst_type_nx = rst_type;
        hold_nx     = hold;
        if (por_cause) begin
            state_nx    = ST_RESET;
            rst_type_nx = RST_POWER_ON;
            hold_nx     = HOLD_INIT;
        end else if (wdt_mres) begin
            state_nx = ST_RESET;
            if (!(state == ST_RESET && rst_type == RST_POWER_ON)) begin
                rst_type_nx = RST_MANUAL;
            end
            hold_nx = HOLD_INIT;
        end else begin
            unique case (state)
                ST_RESET: begin
                    if (hold == HOLD_W'(1)) state_nx = ST_RUN;
                    else                    hold_nx  = hold - HOLD_W'(1);
                end
                ST_RUN:     if (sleep_req && sbycr.sby) state_nx = ST_STANDBY;
                ST_STANDBY: if (nmi_prev && !nmi_n)     state_nx = ST_WAKE;
                ST_WAKE:    if (wdt_ovf)                state_nx = ST_RUN;
            endcase
        end
    end

    // Outputs decoded from the registered state, plus the exit pulse on the WAKE->RUN tick.
    always_comb begin
        sby       = (state == ST_STANDBY);
        pres      = (state == ST_RESET) && (rst_type == RST_POWER_ON);
        mres      = (state == ST_RESET) && (rst_type == RST_MANUAL);
        stby_exit = tick && (state == ST_WAKE) && (state_nx == ST_RUN);
        psc_halt  = (state == ST_STANDBY);
        psc_clear = (state == ST_RUN) && (state_nx == ST_STANDBY);
    end

    // SBYCR: cleared by power-on causes, kept through manual reset, written on ticks.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sbycr <= SBYCR_INIT;
        end else if (tick) begin
            if (por_cause)   sbycr <= SBYCR_INIT;
            else if (reg_wr) sbycr <= sbycr_t'(bus.ibus_di[7:0] & SBYCR_WMASK);
        end
    end

    // Read data is captured on the falling phase and mirrored into all byte lanes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= '0;
        end else if (ce_f) begin
            rd_data <= {4{sbycr & SBYCR_RMASK}};
        end
    end

    assign bus.ibus_do   = reg_sel ? rd_data : '0;
    assign bus.ibus_busy = 1'b0;
    assign bus.ibus_act  = reg_sel;

    // Byte lanes are irrelevant: the register is byte-wide and mirrored on reads.
    logic unused_bus;
    assign unused_bus = ^{bus.ibus_ba, bus.ibus_di[31:8]};

    assign hiz = sbycr.hiz;
`ifdef SH7604_MSTP_EN
    assign mstp = sbycr.mstp;
`else
    assign mstp = '0;
`endif

    sh7604_sysctl_prescaler u_prescaler (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (tick),
        .clear (psc_clear),
        .halt  (psc_halt),
        .ce    (ce_vec)
    );

    assign {clk8192_ce, clk4096_ce, clk1024_ce, clk512_ce,
            clk256_ce, clk128_ce, clk64_ce, clk2_ce} = ce_vec;
endmodule

// File: tb/tb_sh7604_sysctl.sv
// tb_sh7604_sysctl -- scoreboard bench for sh7604_sysctl with a behavioural model.
module tb_sh7604_sysctl;
    localparam int RST_HOLD = 16;
    localparam logic [31:0] SBYCR_A = 32'hFFFF_FE91;
    localparam logic [31:0] OTHER_A = 32'h0000_1000;
`ifdef SH7604_MSTP_EN
    localparam logic [7:0] REG_MASK = 8'hDF;
    localparam bit         HAS_MSTP = 1'b1;
`else
    localparam logic [7:0] REG_MASK = 8'hC0;
    localparam bit         HAS_MSTP = 1'b0;
`endif
    localparam int PH_RESET = 0, PH_RUN = 1, PH_STBY = 2, PH_WAKE = 3;

    typedef struct packed {
        logic [7:0]  ce;
        logic        sby, pres, mres, stby_exit, hiz;
        logic [4:0]  mstp;
        logic [31:0] rdata;
        logic        act, busy;
    } obs_t;

    int total = 0;
    int bad   = 0;
    int div_tab [8] = '{2, 64, 128, 256, 512, 1024, 4096, 8192};
    obs_t exp_q [$];

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, ce_r, ce_f, en, res_n, nmi_n, sleep_req, wdt_pres, wdt_mres, wdt_ovf;
    logic clk2_ce, clk64_ce, clk128_ce, clk256_ce, clk512_ce, clk1024_ce, clk4096_ce, clk8192_ce;
    logic sby, pres, mres, stby_exit, hiz;
    logic [4:0] mstp;

    sh7604_sysctl_if bus ();

    sh7604_sysctl #(.RST_HOLD(RST_HOLD)) dut (
        .clk(clk), .rst_n(rst_n), .ce_r(ce_r), .ce_f(ce_f), .en(en),
        .res_n(res_n), .nmi_n(nmi_n), .sleep_req(sleep_req),
        .wdt_pres(wdt_pres), .wdt_mres(wdt_mres), .wdt_ovf(wdt_ovf),
        .bus(bus),
        .clk2_ce(clk2_ce), .clk64_ce(clk64_ce), .clk128_ce(clk128_ce),
        .clk256_ce(clk256_ce), .clk512_ce(clk512_ce), .clk1024_ce(clk1024_ce),
        .clk4096_ce(clk4096_ce), .clk8192_ce(clk8192_ce),
        .sby(sby), .pres(pres), .mres(mres), .stby_exit(stby_exit),
        .hiz(hiz), .mstp(mstp)
    );

    // Behavioural model: phase, reset flavour, ticks since the reset cause cleared,
    // free-running tick count for the prescaler, register and read-capture bytes.
    int         ph;
    bit         po;
    int         quiet_ticks;
    int         psc;
    logic [7:0] m_sbycr, m_latch;
    logic       m_nmi_prev;

    function automatic obs_t expect_now();
        obs_t o;
        bit   tick = en && ce_r;
        bit   sel  = (bus.ibus_a == SBYCR_A);
        for (int i = 0; i < 8; i++)
            o.ce[i] = (ph != PH_STBY) && ((psc % div_tab[i]) == div_tab[i] - 1);
        o.sby       = (ph == PH_STBY);
        o.pres      = (ph == PH_RESET) && po;
        o.mres      = (ph == PH_RESET) && !po;
        o.stby_exit = rst_n && tick && (ph == PH_WAKE) && wdt_ovf && res_n && !wdt_pres && !wdt_mres;
        o.hiz       = m_sbycr[6];
        o.mstp      = HAS_MSTP ? m_sbycr[4:0] : 5'd0;
        o.rdata     = sel ? {4{m_latch}} : 32'd0;
        o.act       = sel;
        o.busy      = 1'b0;
        return o;
    endfunction

    task automatic advance();
        logic [7:0] old;
        bit tick, pc, mc, enter_sby, sel;
        if (rst_n) begin
            old  = m_sbycr;
            tick = en && ce_r;
            sel  = (bus.ibus_a == SBYCR_A);
            if (ce_f) m_latch = old;
            if (tick) begin
                pc = !res_n || wdt_pres;
                mc = wdt_mres;
                enter_sby = (ph == PH_RUN) && sleep_req && old[7] && !pc && !mc;
                if (ph != PH_STBY) psc = enter_sby ? 0 : (psc + 1) % 8192;
                if (pc) begin
                    ph = PH_RESET; po = 1'b1; quiet_ticks = 0;
                end else if (mc) begin
                    po = (ph == PH_RESET) && po; ph = PH_RESET; quiet_ticks = 0;
                end else begin
                    case (ph)
                        PH_RESET: begin
                            quiet_ticks++;
                            if (quiet_ticks == RST_HOLD) ph = PH_RUN;
                        end
                        PH_RUN:  if (enter_sby) ph = PH_STBY;
                        PH_STBY: if (m_nmi_prev && !nmi_n) ph = PH_WAKE;
                        default: if (wdt_ovf) ph = PH_RUN;
                    endcase
                end
                if (pc) m_sbycr = 8'h00;
                else if (sel && bus.ibus_we && bus.ibus_req) m_sbycr = bus.ibus_di[7:0] & REG_MASK;
                m_nmi_prev = nmi_n;
            end
        end
    endtask

    task automatic check(input string name, input int cyc, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cycle=%0d actual=%h required=%h", name, cyc, act, exp);
        end
    endtask

    // Monitor: pops one expectation per cycle and compares the settled outputs.
    initial begin : monitor
        obs_t e;
        int   cyc = 0;
        forever begin
            @(negedge clk);
            #2;
            cyc++;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("clk_ce", cyc, {24'd0, clk8192_ce, clk4096_ce, clk1024_ce, clk512_ce,
                                      clk256_ce, clk128_ce, clk64_ce, clk2_ce}, {24'd0, e.ce});
                check("sby", cyc, {31'd0, sby}, {31'd0, e.sby});
                check("pres", cyc, {31'd0, pres}, {31'd0, e.pres});
                check("mres", cyc, {31'd0, mres}, {31'd0, e.mres});
                check("stby_exit", cyc, {31'd0, stby_exit}, {31'd0, e.stby_exit});
                check("hiz", cyc, {31'd0, hiz}, {31'd0, e.hiz});
                check("mstp", cyc, {27'd0, mstp}, {27'd0, e.mstp});
                check("ibus_do", cyc, bus.ibus_do, e.rdata);
                check("ibus_act", cyc, {31'd0, bus.ibus_act}, {31'd0, e.act});
                check("ibus_busy", cyc, {31'd0, bus.ibus_busy}, {31'd0, e.busy});
            end
        end
    end

    // One cycle: record what the DUT must show for the current inputs, then move the model.
    task automatic step();
        exp_q.push_back(expect_now());
        advance();
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic quiet();
        sleep_req = 1'b0; wdt_pres = 1'b0; wdt_mres = 1'b0; wdt_ovf = 1'b0;
        bus.ibus_a = OTHER_A; bus.ibus_di = 32'd0; bus.ibus_ba = 4'd0;
        bus.ibus_we = 1'b0; bus.ibus_req = 1'b0;
    endtask

    task automatic wr(input logic [7:0] d);
        logic [31:0] r;
        r = $urandom();
        bus.ibus_a = SBYCR_A; bus.ibus_di = {r[31:8], d}; bus.ibus_ba = 4'b0001;
        bus.ibus_we = 1'b1; bus.ibus_req = 1'b1;
        step();
        bus.ibus_we = 1'b0; bus.ibus_req = 1'b0; bus.ibus_a = OTHER_A;
    endtask

    task automatic rd();
        bus.ibus_a = SBYCR_A; bus.ibus_req = 1'b1;
        step(); step();
        bus.ibus_req = 1'b0; bus.ibus_a = OTHER_A;
    endtask

    task automatic pulse_sleep();
        sleep_req = 1'b1; step(); sleep_req = 1'b0;
    endtask

    task automatic pulse_ovf();
        wdt_ovf = 1'b1; step(); wdt_ovf = 1'b0;
    endtask

    initial begin : driver
        int waited;
        logic [31:0] r;
        ph = PH_RESET; po = 1'b1; quiet_ticks = 0; psc = 0;
        m_sbycr = 8'h00; m_latch = 8'h00; m_nmi_prev = 1'b1;
        rst_n = 1'b0; ce_r = 1'b1; ce_f = 1'b1; en = 1'b1; res_n = 1'b1; nmi_n = 1'b1;
        quiet();
        @(negedge clk);
        idle(3);
        rst_n = 1'b1;
        idle(20);                          // reset hold release
        idle(8300);                        // all prescaler taps incl. 1FFF wrap

        wr(8'h80); rd(); wr(8'hFF); rd(); wr(8'h80); rd();

        pulse_sleep(); idle(10);           // enter standby, enables frozen
        nmi_n = 1'b0; step(); idle(4); nmi_n = 1'b1;
        idle(3); pulse_ovf(); idle(3);

        nmi_n = 1'b0; pulse_sleep(); idle(5);   // NMI already low: no wake
        nmi_n = 1'b1; step(); nmi_n = 1'b0; step(); idle(2);
        pulse_ovf(); nmi_n = 1'b1; idle(3);

        wdt_mres = 1'b1; step(); wdt_mres = 1'b0; idle(20); rd();
        wdt_pres = 1'b1; step(); wdt_pres = 1'b0; idle(20); rd();
        wdt_pres = 1'b1; wdt_mres = 1'b1; step(); quiet(); idle(20);

        wr(8'h80); pulse_sleep(); nmi_n = 1'b0; step(); nmi_n = 1'b1; idle(2);
        res_n = 1'b0; step(); res_n = 1'b1; idle(20);

        wr(8'h00); pulse_sleep(); idle(2);      // SBY clear: SLEEP ignored
        sleep_req = 1'b1; wr(8'hC0); sleep_req = 1'b0; idle(2);
        pulse_sleep(); idle(2); nmi_n = 1'b0; step(); nmi_n = 1'b1; pulse_ovf(); idle(3);

        for (int i = 0; i < 4000; i++) begin
            en        = ($urandom() % 8) != 0;
            ce_r      = ($urandom() % 4) != 0;
            ce_f      = ($urandom() % 2) != 0;
            res_n     = ($urandom() % 200) != 0;
            wdt_pres  = ($urandom() % 300) == 0;
            wdt_mres  = ($urandom() % 250) == 0;
            sleep_req = ($urandom() % 10) == 0;
            wdt_ovf   = ($urandom() % 20) == 0;
            if (($urandom() % 8) == 0) nmi_n = ~nmi_n;
            r = $urandom();
            bus.ibus_a   = (($urandom() % 4) == 0) ? SBYCR_A : r;
            bus.ibus_di  = $urandom();
            bus.ibus_ba  = 4'($urandom());
            bus.ibus_we  = ($urandom() % 2) != 0;
            bus.ibus_req = ($urandom() % 2) != 0;
            step();
        end
        en = 1'b1; ce_r = 1'b1; ce_f = 1'b1; res_n = 1'b1; nmi_n = 1'b1;
        quiet(); idle(5);

        waited = 0;
        while (exp_q.size() != 0 && waited < 10) begin
            @(negedge clk);
            waited++;
        end
        #3;
        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain pending=%0d required=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
